// File: rtl/vector_store_serializer_pkg.sv
// Shared constants, vector/beat types and FSM states for the vector store serializer.
package vec_pkg;
  localparam int N     = 32;
  localparam int V     = 20;
  localparam int L     = 4;
  localparam int AW    = 16;
  localparam int BEATS = (V + L - 1) / L;
  localparam int CW    = $clog2(BEATS + 1);

  typedef logic [V-1:0][N-1:0] vec_t;
  typedef logic [L-1:0][N-1:0] beat_t;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
endpackage

// File: rtl/vector_store_serializer_if.sv
// Pipeline-side request and memory-side beat bus of the vector store serializer.
// VEC_STORE_MASK_EN adds the per-element store mask.
interface vector_store_serializer_if;
  import vec_pkg::*;
  logic          start;
  logic [AW-1:0] base_addr;
  vec_t          vec;
`ifdef VEC_STORE_MASK_EN
  logic [V-1:0]  mask;
`endif
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  beat_t         mem_wdata;
  logic [L-1:0]  mem_be;
  logic          stall;
  logic          done;

  modport slave (
    output mem_we, mem_addr, mem_wdata, mem_be, stall, done,
    input  start, base_addr, vec, mem_ready
`ifdef VEC_STORE_MASK_EN
    , mask
`endif
  );
  modport master (
    input  mem_we, mem_addr, mem_wdata, mem_be, stall, done,
    output start, base_addr, vec, mem_ready
`ifdef VEC_STORE_MASK_EN
    , mask
`endif
  );
endinterface

// File: rtl/vector_beat_slicer.sv
// Combinational beat select: lane j of beat b carries element b*L+j; tail lanes are zero.
// VEC_STORE_MASK_EN folds the element mask into the lane enables.
module vector_beat_slicer
  import vec_pkg::*;
(
  input  vec_t          vec,
  input  logic [CW-1:0] beat,
`ifdef VEC_STORE_MASK_EN
  input  logic [V-1:0]  mask,
`endif
  output beat_t         data,
  output logic [L-1:0]  be,
  output logic          none
);
  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [BEATS-1:0][N-1:0] cand;
    logic [BEATS-1:0]        ok;
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      if (b * L + j < V) begin : g_in
        assign cand[b] = vec[b*L+j];
`ifdef VEC_STORE_MASK_EN
        assign ok[b]   = mask[b*L+j];
`else
        assign ok[b]   = 1'b1;
`endif
      end else begin : g_tail
        assign cand[b] = '0;
        assign ok[b]   = 1'b0;
      end
    end
    assign data[j] = cand[beat];
    assign be[j]   = ok[beat];
  end

  assign none = ~|be;
endmodule

// File: rtl/vector_store_serializer.sv
// MEM-stage store serializer: captures a V-element vector and writes it as L-lane beats.
// VEC_STORE_MASK_EN enables per-element masking and skipping of fully masked beats.
module vector_store_serializer
  import vec_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  vector_store_serializer_if.slave bus
);
  state_t        state;
  vec_t          vec_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt;
  logic [V-1:0]  mask_q;
  beat_t         data;
  logic [L-1:0]  be;
  logic          none;
  logic          in_write;
  logic          accept;

  vector_beat_slicer u_slicer (
    .vec  (vec_q),
    .beat (cnt),
`ifdef VEC_STORE_MASK_EN
    .mask (mask_q),
`endif
    .data (data),
    .be   (be),
    .none (none)
  );

  assign in_write      = (state == WRITE);
  // A fully masked beat retires on its own without a memory handshake.
  assign accept        = bus.mem_ready | none;
  assign bus.stall     = in_write;
  assign bus.mem_we    = in_write & ~none;
  assign bus.mem_wdata = in_write ? data : '0;
  assign bus.mem_be    = in_write ? be : '0;
  assign bus.mem_addr  = in_write ? addr_q : '0;
  assign bus.done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec_q  <= '0;
      addr_q <= '0;
      cnt    <= '0;
      mask_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            vec_q  <= bus.vec;
            addr_q <= bus.base_addr;
            cnt    <= '0;
`ifdef VEC_STORE_MASK_EN
            mask_q <= bus.mask;
`else
            mask_q <= '1;
`endif
            state  <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (accept) begin
            addr_q <= addr_q + AW'(L);
            if (cnt == CW'(BEATS - 1)) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer; mask scenario compiled in with VEC_STORE_MASK_EN.
module tb_vector_store_serializer;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t va, vb, vc;
  logic [V-1:0] mtb = '1;

  vector_store_serializer_if bus();

  vector_store_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic beat_t exp_beat(vec_t v, int b);
    beat_t r;
    int    idx;
    r = '0;
    for (int j = 0; j < L; j++) begin
      idx = b * L + j;
      if (idx < V) r[j] = v[idx];
    end
    return r;
  endfunction

  function automatic logic [L-1:0] exp_be(int b, logic [V-1:0] m);
    logic [L-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < L; j++) begin
      idx = b * L + j;
      if (idx < V) r[j] = m[idx];
    end
    return r;
  endfunction

  // Present a one-cycle start; returns at the negedge where beat 0 is visible.
  task automatic issue(input logic [AW-1:0] base, input vec_t v);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.vec       = v;
`ifdef VEC_STORE_MASK_EN
    bus.mask      = mtb;
`endif
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!bus.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.done, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mem_ready = 1'b0; bus.base_addr = '0; bus.vec = '0;
`ifdef VEC_STORE_MASK_EN
    bus.mask = '1;
`endif
    #3;
    n_checks++;
    if ({bus.mem_we, bus.stall, bus.done, bus.mem_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: we=%b stall=%b done=%b be=%b, required all 0",
               bus.mem_we, bus.stall, bus.done, bus.mem_be);
    end
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.mem_ready = 1'b1;
    issue(16'h0100, va);
    for (int b = 0; b < BEATS; b++) begin
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.stall !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_ctrl beat %0d: we=%b stall=%b done=%b, required 1 1 0",
                 b, bus.mem_we, bus.stall, bus.done);
      end
      n_checks++;
      if (bus.mem_addr !== AW'(16'h0100 + b * L)) begin
        n_fail++;
        $display("FAIL basic_addr beat %0d: got %h, required %h", b, bus.mem_addr, AW'(16'h0100 + b * L));
      end
      n_checks++;
      if (bus.mem_wdata !== exp_beat(va, b) || bus.mem_be !== exp_be(b, mtb)) begin
        n_fail++;
        $display("FAIL basic_data beat %0d: got %h be %b, required %h be %b",
                 b, bus.mem_wdata, bus.mem_be, exp_beat(va, b), exp_be(b, mtb));
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b stall=%b we=%b, required 1 0 0", bus.done, bus.stall, bus.mem_we);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: done=%b stall=%b, required 0 0", bus.done, bus.stall);
    end
  endtask

  task automatic test_ready_toggle();
    int k, cyc;
    k = 0;
    cyc = 0;
    bus.mem_ready = 1'b0;
    issue(16'h0100, va);
    while (bus.stall === 1'b1 && cyc < 40) begin
      n_checks++;
      if (bus.mem_we !== 1'b1 || k >= BEATS || bus.mem_addr !== AW'(16'h0100 + k * L)
          || bus.mem_wdata !== exp_beat(va, k)) begin
        n_fail++;
        $display("FAIL toggle_beat cyc %0d: we=%b addr=%h wdata=%h, required beat %0d addr %h wdata %h",
                 cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, k, AW'(16'h0100 + k * L), exp_beat(va, k));
      end
      bus.mem_ready = (cyc % 2 == 0);
      if (bus.mem_ready) k++;
      @(negedge clk);
      cyc++;
    end
    bus.mem_ready = 1'b1;
    n_checks++;
    if (k !== BEATS || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_count: accepted %0d done=%b, required %0d 1", k, bus.done, BEATS);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bus.mem_ready = 1'b1;
    issue(16'hFFFC, va);
    n_checks++;
    if (bus.mem_addr !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL wrap_beat0: addr=%h, required fffc", bus.mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== exp_beat(va, 1)) begin
      n_fail++;
      $display("FAIL wrap_beat1: addr=%h wdata=%h, required 0000 %h", bus.mem_addr, bus.mem_wdata, exp_beat(va, 1));
    end
    wait_done("wrap");
  endtask

  task automatic test_back_to_back();
    bus.mem_ready = 1'b1;
    issue(16'h0100, va);
    repeat (BEATS) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b, required 1", bus.done);
    end
    bus.start = 1'b1; bus.base_addr = 16'h0200; bus.vec = vb;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.done !== 1'b0 || bus.mem_addr !== 16'h0200 || bus.mem_wdata !== exp_beat(vb, 0)) begin
      n_fail++;
      $display("FAIL b2b_first: we=%b done=%b addr=%h wdata=%h, required 1 0 0200 %h",
               bus.mem_we, bus.done, bus.mem_addr, bus.mem_wdata, exp_beat(vb, 0));
    end
    // A second request while busy must not disturb the store in flight.
    bus.mem_ready = 1'b0;
    bus.start = 1'b1; bus.base_addr = 16'h0300; bus.vec = vc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mem_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      n_checks++;
      if (bus.mem_addr !== AW'(16'h0200 + b * L) || bus.mem_wdata !== exp_beat(vb, b)) begin
        n_fail++;
        $display("FAIL b2b_ignore beat %0d: addr=%h wdata=%h, required %h %h",
                 b, bus.mem_addr, bus.mem_wdata, AW'(16'h0200 + b * L), exp_beat(vb, b));
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end: done=%b, required 1", bus.done);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_restart: stall=%b, required 0", bus.stall);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    seen_done = 1'b0;
    bus.mem_ready = 1'b1;
    issue(16'h0400, va);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 16'h0408) begin
      n_fail++;
      $display("FAIL rstmid_beat2: addr=%h, required 0408", bus.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_we, bus.stall, bus.done, bus.mem_be} !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: we=%b stall=%b done=%b be=%b addr=%h, required all 0",
               bus.mem_we, bus.stall, bus.done, bus.mem_be, bus.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: done seen=%b stall=%b, required 0 0", seen_done, bus.stall);
    end
    issue(16'h0500, vb);
    n_checks++;
    if (bus.mem_addr !== 16'h0500 || bus.mem_wdata !== exp_beat(vb, 0)) begin
      n_fail++;
      $display("FAIL rstmid_restart: addr=%h wdata=%h, required 0500 %h", bus.mem_addr, bus.mem_wdata, exp_beat(vb, 0));
    end
    wait_done("rstmid");
  endtask

`ifdef VEC_STORE_MASK_EN
  task automatic test_mask();
    int strobes, cyc;
    strobes = 0;
    cyc = 0;
    mtb = V'(20'h000F0);
    bus.mem_ready = 1'b1;
    issue(16'h0100, va);
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.mem_we === 1'b1) begin
        strobes++;
        n_checks++;
        if (bus.mem_addr !== 16'h0104 || bus.mem_be !== 4'b1111 || bus.mem_wdata !== exp_beat(va, 1)) begin
          n_fail++;
          $display("FAIL mask_strobe: addr=%h be=%b, required 0104 1111", bus.mem_addr, bus.mem_be);
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (strobes !== 1 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_count: strobes=%0d done=%b, required 1 1", strobes, bus.done);
    end
    mtb = '1;
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < V; i++) begin
      va[i] = N'(i);
      vb[i] = 32'h0000_1000 + N'(i);
      vc[i] = 32'hDEAD_0000 + N'(i);
    end
    test_reset();
    test_basic();
    test_ready_toggle();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef VEC_STORE_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
